fetch_unit: RTL and testbench

- Instruction fetch front end that sits on the driving side of the program counter register.
- Reads the current PC, issues req/ack reads to instruction memory, and presents fetched words to decode over a valid/ready interface.
- Drives the PC's increment and load controls: increments on each accepted fetch, loads on branch/jump redirects from execute.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_buf.sv | 48 ++++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and FSM state encodings for the instruction fetch unit.
// No ports; imported by fetch_unit and fetch_buf.
package fetch_pkg;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_INSTR_W = 16;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        HOLD  = ST_HOLD,
        DRAIN = ST_DRAIN
    } state_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry in-order FIFO of {pc, instr} used by the prefetching fetch unit.
// Ports: clk/rst; push_i with pc_i/instr_i writes the tail; pop_i retires the head;
// flush_i empties the FIFO; pc_o/instr_o show the head; count_o is occupancy (0..2).
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [1:0]         count_o
);
    logic [ADDR_W+INSTR_W-1:0] mem_q [2];
    logic                      wr_q, rd_q;
    logic [1:0]                cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else if (flush_i) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= {pc_i, instr_i};
                wr_q        <= ~wr_q;
            end
            if (pop_i)
                rd_q <= ~rd_q;
            cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign {pc_o, instr_o} = mem_q[rd_q];
    assign count_o         = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end driving PC inc/load, memory req/ack and a valid/ready decode port.
// Ports: clk/rst (sync, active-high); pc_q current PC; pc_inc/pc_ld/pc_ld_val PC controls;
// mem_req/mem_addr/mem_ack/mem_rdata memory read; ir_valid/ir_ready/ir_data/ir_pc decode port;
// redir/redir_addr redirect from execute. Define FETCH_PREFETCH_EN for a 2-entry prefetch buffer.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_q,
    output logic               pc_inc,
    output logic               pc_ld,
    output logic [ADDR_W-1:0]  pc_ld_val,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc,
    input  logic               redir,
    input  logic [ADDR_W-1:0]  redir_addr
);
    state_t              state_q, state_d;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q, addr_d;
    logic                buf_full_d;

    // Load wins over increment, so an ack in a redirect cycle never advances the PC.
    assign pc_ld     = !rst && redir;
    assign pc_ld_val = pc_ld ? redir_addr : '0;
    assign pc_inc    = !rst && !redir && state_q == REQ && mem_ack;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

`ifdef FETCH_PREFETCH_EN
    logic [1:0] cnt;
    logic       pop;
    assign pop = ir_valid && ir_ready && !redir;
    fetch_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pc_inc),
        .pop_i   (pop),
        .flush_i (redir),
        .pc_i    (mem_addr_q),
        .instr_i (mem_rdata),
        .pc_o    (ir_pc),
        .instr_o (ir_data),
        .count_o (cnt)
    );
    assign ir_valid   = cnt != 2'd0;
    // An in-flight request reserves a slot, so only request again when at most one entry remains.
    assign buf_full_d = (cnt + 2'(pc_inc) - 2'(pop)) == 2'd2;
`else
    logic               ir_valid_q;
    logic [INSTR_W-1:0] ir_data_q;
    logic [ADDR_W-1:0]  ir_pc_q;
    assign buf_full_d = pc_inc || (state_q == HOLD && !ir_ready);
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_valid_q <= 1'b0;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
        end else begin
            ir_valid_q <= state_d == HOLD;
            if (pc_inc) begin
                ir_data_q <= mem_rdata;
                ir_pc_q   <= mem_addr_q;
            end
        end
    end
    assign ir_valid = ir_valid_q;
    assign ir_data  = ir_data_q;
    assign ir_pc    = ir_pc_q;
`endif

    // Address for a fresh request: the redirect target, else the PC as it will read after this edge.
    assign addr_d = redir ? redir_addr : pc_inc ? pc_q + ADDR_W'(1) : pc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = REQ;
            REQ:   state_d = redir ? (mem_ack ? REQ : DRAIN) : (mem_ack && buf_full_d) ? HOLD : REQ;
            HOLD:  state_d = (redir || !buf_full_d) ? REQ : HOLD;
            DRAIN: state_d = mem_ack ? REQ : DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= state_d == REQ || state_d == DRAIN;
            // Address is held while a request waits for its ack; a new one is latched on every REQ entry.
            if (state_d == REQ && !(state_q == REQ && !mem_ack))
                mem_addr_q <= addr_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a PC register and wait-state memory model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_q;
    logic        pc_inc, pc_ld;
    logic [15:0] pc_ld_val;
    logic        mem_req, mem_ack;
    logic [15:0] mem_addr, mem_rdata;
    logic        ir_valid, ir_ready;
    logic [15:0] ir_data, ir_pc;
    logic        redir;
    logic [15:0] redir_addr;

    int          nwait = 0;
    int          wcnt = 0;
    logic [15:0] pc_init = 16'h0000;
    int          inc_cnt = 0, ld_cnt = 0, both_cnt = 0;
    int          checks = 0, errors = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .pc_q(pc_q), .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_ld_val(pc_ld_val),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
        .redir(redir), .redir_addr(redir_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) pc_q <= pc_init;
        else if (pc_ld) pc_q <= pc_ld_val;
        else if (pc_inc) pc_q <= pc_q + 16'd1;
    end

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end
    assign mem_ack   = mem_req && (wcnt == nwait);
    assign mem_rdata = 16'h1000 + mem_addr;

    always @(posedge clk) begin
        if (pc_inc) inc_cnt <= inc_cnt + 1;
        if (pc_ld) ld_cnt <= ld_cnt + 1;
        if (pc_inc && pc_ld) both_cnt <= both_cnt + 1;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_expect(input logic [15:0] exp_pc, output int cyc);
        logic [15:0] exp_data;
        exp_data = 16'h1000 + exp_pc;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!ir_valid && cyc < 20);
        checks++;
        if (ir_valid !== 1'b1)
            begin errors++; $display("FAIL fetch_timeout pc=%h: ir_valid=%b required 1", exp_pc, ir_valid); end
        checks++;
        if (ir_pc !== exp_pc || ir_data !== exp_data)
            begin errors++; $display("FAIL fetch_word: ir_pc=%h ir_data=%h required %h %h", ir_pc, ir_data, exp_pc, exp_data); end
    endtask

    task automatic test_reset;
        pc_init = 16'h0000; nwait = 0; ir_ready = 1'b1;
        redir = 1'b1; redir_addr = 16'h1234; rst = 1'b1;
        step(); step();
        checks++;
        if ({pc_inc, pc_ld, mem_req, ir_valid} !== 4'b0000)
            begin errors++; $display("FAIL reset_ctrl: inc/ld/req/valid=%b required 0000", {pc_inc, pc_ld, mem_req, ir_valid}); end
        checks++;
        if (pc_ld_val !== 16'h0 || mem_addr !== 16'h0 || ir_data !== 16'h0 || ir_pc !== 16'h0)
            begin errors++; $display("FAIL reset_data: ld_val=%h addr=%h data=%h pc=%h required all 0", pc_ld_val, mem_addr, ir_data, ir_pc); end
        rst = 1'b0; redir = 1'b0;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000)
            begin errors++; $display("FAIL first_req: req=%b addr=%h required 1 0000", mem_req, mem_addr); end
    endtask

    task automatic apply_reset(input logic [15:0] init);
        pc_init = init; nwait = 0; ir_ready = 1'b1; redir = 1'b0; rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_sequential;
        int cyc, inc0, ld0;
        inc0 = inc_cnt; ld0 = ld_cnt;
        fetch_expect(16'h0000, cyc);
        fetch_expect(16'h0001, cyc);
        fetch_expect(16'h0002, cyc);
        checks++;
        if (cyc !== 2)
            begin errors++; $display("FAIL seq_rate: cycles/word=%0d required 2", cyc); end
        checks++;
        if (inc_cnt - inc0 !== 3 || ld_cnt - ld0 !== 0)
            begin errors++; $display("FAIL seq_pc_ctrl: inc=%0d ld=%0d required 3 0", inc_cnt - inc0, ld_cnt - ld0); end
    endtask

    task automatic test_hold;
        int cyc;
        fetch_expect(16'h0003, cyc);
        fetch_expect(16'h0004, cyc);
        ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (ir_valid !== 1'b1 || ir_data !== 16'h1004 || ir_pc !== 16'h0004 || mem_req !== 1'b0 || pc_inc !== 1'b0)
                begin errors++; $display("FAIL hold_stable cyc%0d: v=%b d=%h pc=%h req=%b inc=%b required 1 1004 0004 0 0", i, ir_valid, ir_data, ir_pc, mem_req, pc_inc); end
        end
        ir_ready = 1'b1;
        step();
        checks++;
        if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0005)
            begin errors++; $display("FAIL hold_accept: v=%b req=%b addr=%h required 0 1 0005", ir_valid, mem_req, mem_addr); end
        fetch_expect(16'h0005, cyc);
    endtask

    task automatic test_redir_wait;
        int cyc, ld0;
        logic held;
        ld0 = ld_cnt;
        nwait = 3;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0006 || mem_ack !== 1'b0)
            begin errors++; $display("FAIL wait_req: req=%b addr=%h ack=%b required 1 0006 0", mem_req, mem_addr, mem_ack); end
        redir = 1'b1; redir_addr = 16'h0040;
        #1;
        checks++;
        if (pc_ld !== 1'b1 || pc_ld_val !== 16'h0040 || pc_inc !== 1'b0)
            begin errors++; $display("FAIL wait_redir_ld: ld=%b val=%h inc=%b required 1 0040 0", pc_ld, pc_ld_val, pc_inc); end
        step();
        redir = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (mem_req !== 1'b1 || mem_addr !== 16'h0006) held = 1'b0;
            if (mem_ack) break;
            step();
        end
        checks++;
        if (held !== 1'b1 || mem_ack !== 1'b1)
            begin errors++; $display("FAIL drain_hold: held=%b ack=%b addr=%h required 1 1 0006", held, mem_ack, mem_addr); end
        checks++;
        if (pc_inc !== 1'b0)
            begin errors++; $display("FAIL drain_no_inc: inc=%b required 0", pc_inc); end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0040)
            begin errors++; $display("FAIL drain_refetch: req=%b addr=%h required 1 0040", mem_req, mem_addr); end
        fetch_expect(16'h0040, cyc);
        checks++;
        if (ld_cnt - ld0 !== 1)
            begin errors++; $display("FAIL wait_ld_count: ld=%0d required 1", ld_cnt - ld0); end
    endtask

    task automatic test_redir_ack;
        int cyc;
        nwait = 0;
        step();
        checks++;
        if (mem_ack !== 1'b1 || mem_addr !== 16'h0041)
            begin errors++; $display("FAIL ack_req: ack=%b addr=%h required 1 0041", mem_ack, mem_addr); end
        redir = 1'b1; redir_addr = 16'h0100;
        #1;
        checks++;
        if (pc_ld !== 1'b1 || pc_inc !== 1'b0 || pc_ld_val !== 16'h0100)
            begin errors++; $display("FAIL ack_redir_ld: ld=%b inc=%b val=%h required 1 0 0100", pc_ld, pc_inc, pc_ld_val); end
        step();
        redir = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0100 || ir_valid !== 1'b0)
            begin errors++; $display("FAIL ack_discard: req=%b addr=%h v=%b required 1 0100 0", mem_req, mem_addr, ir_valid); end
        fetch_expect(16'h0100, cyc);
    endtask

    task automatic test_wrap;
        int cyc, inc0;
        apply_reset(16'hFFFF);
        step();
        inc0 = inc_cnt;
        fetch_expect(16'hFFFF, cyc);
        checks++;
        if (inc_cnt - inc0 !== 1)
            begin errors++; $display("FAIL wrap_inc: inc=%0d required 1", inc_cnt - inc0); end
        fetch_expect(16'h0000, cyc);
    endtask

    task automatic test_redir_hold;
        int cyc;
        redir = 1'b1; redir_addr = 16'h0200;
        #1;
        checks++;
        if (pc_ld !== 1'b1 || pc_ld_val !== 16'h0200)
            begin errors++; $display("FAIL hold_redir_ld: ld=%b val=%h required 1 0200", pc_ld, pc_ld_val); end
        step();
        redir = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0200)
            begin errors++; $display("FAIL hold_redir_drop: v=%b req=%b addr=%h required 0 1 0200", ir_valid, mem_req, mem_addr); end
        fetch_expect(16'h0200, cyc);
    endtask

    task automatic test_redir_idle;
        int cyc;
        apply_reset(16'h0000);
        redir = 1'b1; redir_addr = 16'h0300;
        #1;
        checks++;
        if (pc_ld !== 1'b1 || pc_ld_val !== 16'h0300)
            begin errors++; $display("FAIL idle_redir_ld: ld=%b val=%h required 1 0300", pc_ld, pc_ld_val); end
        step();
        redir = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0300)
            begin errors++; $display("FAIL idle_redir_req: req=%b addr=%h required 1 0300", mem_req, mem_addr); end
        fetch_expect(16'h0300, cyc);
    endtask

    task automatic test_prefetch;
        int cyc;
        fetch_expect(16'h0000, cyc);
        for (int k = 1; k < 6; k++) begin
            fetch_expect(16'(k), cyc);
            checks++;
            if (cyc !== 1)
                begin errors++; $display("FAIL pf_rate word%0d: cycles=%0d required 1", k, cyc); end
        end
        ir_ready = 1'b0;
        step(); step();
        checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'h0005 || mem_req !== 1'b0)
            begin errors++; $display("FAIL pf_full: v=%b pc=%h req=%b required 1 0005 0", ir_valid, ir_pc, mem_req); end
        redir = 1'b1; redir_addr = 16'h0080; ir_ready = 1'b1;
        #1;
        checks++;
        if (pc_ld !== 1'b1 || pc_ld_val !== 16'h0080)
            begin errors++; $display("FAIL pf_redir_ld: ld=%b val=%h required 1 0080", pc_ld, pc_ld_val); end
        step();
        redir = 1'b0;
        checks++;
        if (ir_valid !== 1'b0)
            begin errors++; $display("FAIL pf_flush: v=%b required 0", ir_valid); end
        fetch_expect(16'h0080, cyc);
    endtask

    initial begin
        test_reset();
`ifdef FETCH_PREFETCH_EN
        test_prefetch();
        test_wrap();
`else
        test_sequential();
        test_hold();
        test_redir_wait();
        test_redir_ack();
        test_wrap();
        test_redir_hold();
        test_redir_idle();
`endif
        checks++;
        if (both_cnt !== 0)
            begin errors++; $display("FAIL inc_ld_overlap: cycles=%0d required 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
